// File: rtl/tmc_spi_pkg.sv
// rtl/tmc_spi_pkg.sv - shared types and limits for the TMC SPI master.
package tmc_spi_pkg;

  localparam int DATA_W_MIN = 2;
  localparam int DATA_W_MAX = 32;
  localparam int NUM_SS_MIN = 1;
  localparam int NUM_SS_MAX = 32;
  localparam int SS_W_MAX   = 5;
  localparam int DIV_W_MAX  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SETUP,
    ST_SHIFT,
    ST_FINISH,
    ST_HOLD
  } tmc_spi_state_t;

  // Sized for the largest legal configuration; the top uses the low bits.
  typedef struct packed {
    logic [DATA_W_MAX-1:0] data;
    logic [SS_W_MAX-1:0]   ss;
    logic                  cpol;
    logic                  cpha;
    logic                  hold;
    logic [DIV_W_MAX-1:0]  div;
    logic                  lsb;
  } tmc_spi_cmd_t;

endpackage

// File: rtl/tmc_spi_clkgen.sv
// rtl/tmc_spi_clkgen.sv - SCLK half-period tick generator, reloadable down-counter.
module tmc_spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (load) begin
      cnt   <= load_div;
      div_q <= load_div;
    end else if (cnt == '0) begin
      cnt <= div_q;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/tmc_spi_master.sv
// rtl/tmc_spi_master.sv - parametrised SPI master with per-command mode, divider and SS hold.
// Optional TMC_SPI_LSB_FIRST_EN adds a per-command cmd_lsb shift-order select.
module tmc_spi_master
  import tmc_spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 12,
  parameter int DIV_W  = 8
) (
  input  logic                                      clk_clk,
  input  logic                                      reset_reset,
  input  logic                                      cmd_valid,
  output logic                                      cmd_ready,
  input  logic [DATA_W-1:0]                         cmd_data,
  input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] cmd_ss,
  input  logic                                      cmd_cpol,
  input  logic                                      cmd_cpha,
  input  logic                                      cmd_hold,
`ifdef TMC_SPI_LSB_FIRST_EN
  input  logic                                      cmd_lsb,
`endif
  input  logic [DIV_W-1:0]                          cmd_div,
  input  logic                                      ss_release,
  output logic                                      rsp_valid,
  output logic [DATA_W-1:0]                         rsp_data,
  output logic                                      busy,
  output logic                                      spi_sclk,
  output logic                                      spi_mosi,
  input  logic                                      spi_miso,
  output logic [NUM_SS-1:0]                         spi_ss_n
);

  localparam int EDGE_W = $clog2(2*DATA_W+1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W-1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || NUM_SS < NUM_SS_MIN ||
      NUM_SS > NUM_SS_MAX || DIV_W > DIV_W_MAX) begin : g_param_check
    $error("tmc_spi_master: parameter out of range");
  end

  tmc_spi_state_t    state;
  tmc_spi_cmd_t      cmd_q, new_cmd, setup_cmd;
  logic [DATA_W-1:0] tx_sr, rx_sr, setup_data;
  logic [EDGE_W-1:0] edge_cnt;
  logic              gap_to_setup, rsp_pend;
  logic              tick, accept, hold_same, go_setup, gap_entry, sample_edge;
  logic [DIV_W-1:0]  clk_div;

  function automatic logic out_bit(input logic [DATA_W-1:0] sr, input logic lsb);
    return lsb ? sr[0] : sr[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] sr, input logic lsb);
    return lsb ? (sr >> 1) : (sr << 1);
  endfunction

  // Out-of-range indices match no bit, so every select stays high.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W_MAX-1:0] ss);
    logic [NUM_SS-1:0] d;
    for (int i = 0; i < NUM_SS; i++) d[i] = (int'(ss) != i);
    return d;
  endfunction

  always_comb begin
    new_cmd      = '0;
    new_cmd.data = DATA_W_MAX'(cmd_data);
    new_cmd.ss   = SS_W_MAX'(cmd_ss);
    new_cmd.cpol = cmd_cpol;
    new_cmd.cpha = cmd_cpha;
    new_cmd.hold = cmd_hold;
    new_cmd.div  = DIV_W_MAX'(cmd_div);
`ifdef TMC_SPI_LSB_FIRST_EN
    new_cmd.lsb  = cmd_lsb;
`else
    new_cmd.lsb  = 1'b0;
`endif
  end

  assign cmd_ready   = (state == ST_IDLE) | ((state == ST_HOLD) & ~ss_release);
  assign busy        = (state != ST_IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign hold_same   = (state == ST_HOLD) && (new_cmd.ss == cmd_q.ss) && (new_cmd.cpol == cmd_q.cpol);
  assign go_setup    = (accept && ((state == ST_IDLE) || hold_same)) ||
                       ((state == ST_GAP) && tick && gap_to_setup);
  assign setup_cmd   = (state == ST_GAP) ? cmd_q : new_cmd;
  assign setup_data  = setup_cmd.data[DATA_W-1:0];
  assign gap_entry   = ((state == ST_FINISH) && tick && !cmd_q.hold) ||
                       ((state == ST_HOLD) && (ss_release || accept));
  assign clk_div     = go_setup ? setup_cmd.div[DIV_W-1:0] :
                       (accept ? new_cmd.div[DIV_W-1:0] : cmd_q.div[DIV_W-1:0]);
  // edge_cnt counts completed edges, so an even count means a leading edge is next.
  assign sample_edge = ~edge_cnt[0] ^ cmd_q.cpha;

  tmc_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .load        (go_setup | gap_entry),
    .load_div    (clk_div),
    .tick        (tick)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      edge_cnt     <= '0;
      gap_to_setup <= 1'b0;
      rsp_pend     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
      spi_ss_n     <= '1;
    end else begin
      rsp_valid <= rsp_pend;
      rsp_pend  <= 1'b0;
      if (rsp_pend) rsp_data <= rx_sr;
      if (go_setup) begin
        state        <= ST_SETUP;
        cmd_q        <= setup_cmd;
        spi_sclk     <= setup_cmd.cpol;
        spi_ss_n     <= ss_decode(setup_cmd.ss);
        edge_cnt     <= '0;
        gap_to_setup <= 1'b0;
        if (!setup_cmd.cpha) begin
          spi_mosi <= out_bit(setup_data, setup_cmd.lsb);
          tx_sr    <= shift_out(setup_data, setup_cmd.lsb);
        end else begin
          tx_sr    <= setup_data;
        end
      end else begin
        case (state)
          ST_SETUP, ST_SHIFT: begin
            if (tick) begin
              spi_sclk <= ~spi_sclk;
              edge_cnt <= edge_cnt + 1'b1;
              if (sample_edge) begin
                rx_sr <= cmd_q.lsb ? {spi_miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], spi_miso};
              end else begin
                spi_mosi <= out_bit(tx_sr, cmd_q.lsb);
                tx_sr    <= shift_out(tx_sr, cmd_q.lsb);
              end
              state <= (edge_cnt == LAST_EDGE) ? ST_FINISH : ST_SHIFT;
            end
          end
          ST_FINISH: begin
            if (tick) begin
              rsp_pend <= 1'b1;
              if (cmd_q.hold) begin
                state <= ST_HOLD;
              end else begin
                state        <= ST_GAP;
                spi_ss_n     <= '1;
                gap_to_setup <= 1'b0;
              end
            end
          end
          ST_HOLD: begin
            if (ss_release) begin
              state        <= ST_GAP;
              spi_ss_n     <= '1;
              gap_to_setup <= 1'b0;
            end else if (accept) begin
              // New slave or polarity: deselect for one gap before the next word.
              state        <= ST_GAP;
              spi_ss_n     <= '1;
              cmd_q        <= new_cmd;
              gap_to_setup <= 1'b1;
            end
          end
          ST_GAP: begin
            if (tick) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmc_spi_master.sv
// tb/tb_tmc_spi_master.sv - directed self-checking bench for tmc_spi_master.
module tb_tmc_spi_master;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_data = '0;
  logic [3:0]  cmd_ss = '0;
  logic        cmd_cpol = 1'b0;
  logic        cmd_cpha = 1'b0;
  logic        cmd_hold = 1'b0;
`ifdef TMC_SPI_LSB_FIRST_EN
  logic        cmd_lsb = 1'b0;
`endif
  logic [7:0]  cmd_div = '0;
  logic        ss_release = 1'b0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [11:0] spi_ss_n;

  logic        loop_en = 1'b1;
  logic        miso_r = 1'b0;
  int          checks = 0;
  int          errors = 0;

  assign spi_miso = loop_en ? spi_mosi : miso_r;

  always #5 clk_clk = ~clk_clk;

  tmc_spi_master #(.DATA_W(8), .NUM_SS(12), .DIV_W(8)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .cmd_ss      (cmd_ss),
    .cmd_cpol    (cmd_cpol),
    .cmd_cpha    (cmd_cpha),
    .cmd_hold    (cmd_hold),
`ifdef TMC_SPI_LSB_FIRST_EN
    .cmd_lsb     (cmd_lsb),
`endif
    .cmd_div     (cmd_div),
    .ss_release  (ss_release),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_ss_n    (spi_ss_n)
  );

  // Offers a command and returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] d, input int ss, input logic cpol, input logic cpha,
                      input logic hold, input int div, input logic lsb);
    logic ok;
    cmd_data = d; cmd_ss = 4'(ss); cmd_cpol = cpol; cmd_cpha = cpha;
    cmd_hold = hold; cmd_div = 8'(div);
`ifdef TMC_SPI_LSB_FIRST_EN
    cmd_lsb = lsb;
`else
    if (lsb) cmd_data = d;
`endif
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk_clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_accept got cmd_ready=0 want 1"); end
  endtask

  // Acts as the slave from the accept (or SETUP entry) onward until rsp_valid.
  task automatic run_xfer(input logic [7:0] sword, input logic cpha, input logic [11:0] exp_ss,
                          output int lat, output int edges, output logic [7:0] mosi_w,
                          output int ss_cnt);
    int   bi;
    logic prev;
    lat = -1; edges = 0; mosi_w = '0; ss_cnt = 0; prev = spi_sclk; bi = 0;
    if (!cpha) begin miso_r = sword[7]; bi = 1; end
    if (spi_ss_n == exp_ss) ss_cnt++;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk_clk); #1;
      if (spi_ss_n == exp_ss) ss_cnt++;
      if (spi_sclk !== prev) begin
        edges++;
        prev = spi_sclk;
        if ((edges % 2 == 1) != cpha) mosi_w = {mosi_w[6:0], spi_mosi};
        else begin
          if (bi < 8) miso_r = sword[7-bi];
          bi++;
        end
      end
      if (rsp_valid) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    repeat (3) @(posedge clk_clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp_data got %h want 00", rsp_data); end
    checks++; if ({spi_sclk, spi_mosi} !== 2'b00) begin errors++; $display("FAIL rst_sclk_mosi got %b want 00", {spi_sclk, spi_mosi}); end
    checks++; if (spi_ss_n !== 12'hFFF) begin errors++; $display("FAIL rst_ss_n got %h want fff", spi_ss_n); end
    reset_reset = 1'b0;
    @(posedge clk_clk); #1;
  endtask

  task automatic test_mode0();
    int lat, e, sc;
    logic [7:0] mw;
    loop_en = 1'b1;
    send(8'hA5, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    checks++; if (spi_mosi !== 1'b1) begin errors++; $display("FAIL m0_first_mosi got %b want 1", spi_mosi); end
    run_xfer(8'h00, 1'b0, 12'hFF7, lat, e, mw, sc);
    checks++; if (lat != 18) begin errors++; $display("FAIL m0_latency got %0d want 18", lat); end
    checks++; if (e != 16) begin errors++; $display("FAIL m0_edges got %0d want 16", e); end
    checks++; if (sc != 17) begin errors++; $display("FAIL m0_ss3_low got %0d want 17", sc); end
    checks++; if (mw !== 8'hA5) begin errors++; $display("FAIL m0_mosi got %h want a5", mw); end
    checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL m0_rsp_data got %h want a5", rsp_data); end
    @(posedge clk_clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_end got %b want 0", busy); end
  endtask

  task automatic test_modes();
    int lat, e, sc;
    logic [7:0] mw;
    loop_en = 1'b0;
    for (int m = 1; m < 4; m++) begin
      send(8'h3C, 1, m[1], m[0], 1'b0, 2, 1'b0);
      run_xfer(8'hC3, m[0], 12'hFFD, lat, e, mw, sc);
      checks++; if (lat != 52) begin errors++; $display("FAIL mode%0d_latency got %0d want 52", m, lat); end
      checks++; if (e != 16) begin errors++; $display("FAIL mode%0d_edges got %0d want 16", m, e); end
      checks++; if (sc != 51) begin errors++; $display("FAIL mode%0d_ss_low got %0d want 51", m, sc); end
      checks++; if (mw !== 8'h3C) begin errors++; $display("FAIL mode%0d_mosi got %h want 3c", m, mw); end
      checks++; if (rsp_data !== 8'hC3) begin errors++; $display("FAIL mode%0d_rsp_data got %h want c3", m, rsp_data); end
      checks++; if (spi_sclk !== m[1]) begin errors++; $display("FAIL mode%0d_sclk_idle got %b want %b", m, spi_sclk, m[1]); end
      repeat (6) @(posedge clk_clk);
      #1;
    end
    checks++; if (rsp_data !== 8'hC3) begin errors++; $display("FAIL rsp_data_hold got %h want c3", rsp_data); end
    loop_en = 1'b1;
  endtask

  task automatic test_hold();
    int lat, e, sc;
    logic [7:0] mw;
    send(8'h11, 5, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_xfer(8'h00, 1'b0, 12'hFDF, lat, e, mw, sc);
    checks++; if (lat != 18 || sc != 19) begin errors++; $display("FAIL hold_w1 got lat=%0d ss=%0d want 18/19", lat, sc); end
    send(8'h22, 5, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_xfer(8'h00, 1'b0, 12'hFDF, lat, e, mw, sc);
    checks++; if (lat != 18 || sc != 19) begin errors++; $display("FAIL hold_w2 got lat=%0d ss=%0d want 18/19", lat, sc); end
    checks++; if (rsp_data !== 8'h22) begin errors++; $display("FAIL hold_rsp got %h want 22", rsp_data); end
    ss_release = 1'b1;
    @(posedge clk_clk); #1;
    ss_release = 1'b0;
    checks++; if (spi_ss_n !== 12'hFFF || busy !== 1'b1) begin errors++; $display("FAIL hold_gap got ss=%h busy=%b want fff/1", spi_ss_n, busy); end
    @(posedge clk_clk); #1;
    checks++; if (spi_ss_n !== 12'hFFF || busy !== 1'b0) begin errors++; $display("FAIL hold_idle got ss=%h busy=%b want fff/0", spi_ss_n, busy); end
  endtask

  task automatic test_hold_switch();
    int lat, e, sc;
    logic [7:0] mw;
    send(8'h33, 5, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_xfer(8'h00, 1'b0, 12'hFDF, lat, e, mw, sc);
    send(8'h44, 6, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    checks++; if (spi_ss_n !== 12'hFFF || busy !== 1'b1) begin errors++; $display("FAIL sw_gap got ss=%h busy=%b want fff/1", spi_ss_n, busy); end
    @(posedge clk_clk); #1;
    checks++; if (spi_ss_n !== 12'hFBF) begin errors++; $display("FAIL sw_ss6 got %h want fbf", spi_ss_n); end
    run_xfer(8'h00, 1'b0, 12'hFBF, lat, e, mw, sc);
    checks++; if (lat != 18 || sc != 19) begin errors++; $display("FAIL sw_w2 got lat=%0d ss=%0d want 18/19", lat, sc); end
    checks++; if (rsp_data !== 8'h44) begin errors++; $display("FAIL sw_rsp got %h want 44", rsp_data); end
    cmd_ss = 4'd6; cmd_valid = 1'b1; ss_release = 1'b1;
    @(negedge clk_clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rel_cmd_ready got %b want 0", cmd_ready); end
    @(posedge clk_clk); #1;
    cmd_valid = 1'b0; ss_release = 1'b0;
    checks++; if (spi_ss_n !== 12'hFFF || busy !== 1'b1) begin errors++; $display("FAIL rel_gap got ss=%h busy=%b want fff/1", spi_ss_n, busy); end
    repeat (4) @(posedge clk_clk);
    #1;
    checks++; if (spi_ss_n !== 12'hFFF || busy !== 1'b0) begin errors++; $display("FAIL rel_idle got ss=%h busy=%b want fff/0", spi_ss_n, busy); end
  endtask

  task automatic test_reset_mid();
    int rsp_seen;
    send(8'h96, 2, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    repeat (13) @(posedge clk_clk);
    #1;
    checks++; if (spi_sclk !== 1'b1 || spi_ss_n !== 12'hFFB) begin errors++; $display("FAIL rm_before got sclk=%b ss=%h want 1/ffb", spi_sclk, spi_ss_n); end
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    checks++; if (spi_ss_n !== 12'hFFF || spi_sclk !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rm_after got ss=%h sclk=%b busy=%b want fff/0/0", spi_ss_n, spi_sclk, busy);
    end
    rsp_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_clk); #1;
      if (rsp_valid) rsp_seen++;
    end
    checks++; if (rsp_seen != 0) begin errors++; $display("FAIL rm_no_rsp got %0d want 0", rsp_seen); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rm_rsp_data got %h want 00", rsp_data); end
  endtask

  task automatic test_bad_ss();
    int lat, e, sc;
    logic [7:0] mw;
    send(8'h5A, 13, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_xfer(8'h00, 1'b0, 12'hFFF, lat, e, mw, sc);
    checks++; if (lat != 18) begin errors++; $display("FAIL bad_ss_latency got %0d want 18", lat); end
    checks++; if (e != 16) begin errors++; $display("FAIL bad_ss_edges got %0d want 16", e); end
    checks++; if (sc != 19) begin errors++; $display("FAIL bad_ss_ss_high got %0d want 19", sc); end
    checks++; if (rsp_data !== 8'h5A) begin errors++; $display("FAIL bad_ss_rsp got %h want 5a", rsp_data); end
    repeat (2) @(posedge clk_clk);
    #1;
  endtask

  task automatic test_lsb();
    int lat, e, sc;
    logic [7:0] mw;
    logic       exp_first;
    logic [7:0] exp_mw;
`ifdef TMC_SPI_LSB_FIRST_EN
    exp_first = 1'b1; exp_mw = 8'h80;
`else
    exp_first = 1'b0; exp_mw = 8'h01;
`endif
    send(8'h01, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    checks++; if (spi_mosi !== exp_first) begin errors++; $display("FAIL lsb_first_mosi got %b want %b", spi_mosi, exp_first); end
    run_xfer(8'h00, 1'b0, 12'hFFE, lat, e, mw, sc);
    checks++; if (mw !== exp_mw) begin errors++; $display("FAIL lsb_wire_order got %h want %h", mw, exp_mw); end
    checks++; if (rsp_data !== 8'h01) begin errors++; $display("FAIL lsb_rsp got %h want 01", rsp_data); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_hold();
    test_hold_switch();
    test_reset_mid();
    test_bad_ss();
    test_lsb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
